// File: rtl/prbs15_checker.sv
// PRBS-15 (x^15+x^14+1) byte-stream checker: self-seeds from two received bytes,
// verifies the prediction before declaring lock, then counts bit errors and checked bytes.
module prbs15_checker #(
   parameter int unsigned LOCK_BYTES = 4,
   parameter int unsigned LOSS_ERRS  = 4,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [7:0]       data_in,
   input  logic             data_valid,
   input  logic             clear,
   output logic             locked,
   output logic             bit_err,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] byte_count
);

   localparam int unsigned MATCH_W = (LOCK_BYTES < 2) ? 1 : $clog2(LOCK_BYTES + 1);
   localparam int unsigned MISS_W  = (LOSS_ERRS < 2) ? 1 : $clog2(LOSS_ERRS + 1);
   localparam int unsigned SUM_W   = CNT_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEED,
      ST_VERIFY,
      ST_LOCKED
   } state_e;

   state_e             state_q, state_d;
   logic [14:0]        lfsr_q, lfsr_d;
   logic [6:0]         b0_q, b0_d;
   logic               have_b0_q, have_b0_d;
   logic [MATCH_W-1:0] match_q, match_d;
   logic [MISS_W-1:0]  miss_q, miss_d;
   logic               locked_q, locked_d;
   logic               bit_err_q, bit_err_d;
   logic [CNT_W-1:0]   err_q, err_d;
   logic [CNT_W-1:0]   byte_q, byte_d;

   logic [14:0]        lfsr_adv;
   logic [7:0]         pred_byte;
   logic [7:0]         diff;
   logic [3:0]         err_pop;
   logic [SUM_W-1:0]   err_sum;
   logic [SUM_W-1:0]   byte_sum;
   logic [CNT_W-1:0]   err_sat;
   logic [CNT_W-1:0]   byte_sat;
   logic [MATCH_W-1:0] match_inc;
   logic [MISS_W-1:0]  miss_inc;

   // Eight LFSR steps: predicted byte (first bit in bit 7) and the advanced state.
   always_comb begin
      lfsr_adv  = lfsr_q;
      pred_byte = '0;
      for (int i = 0; i < 8; i++) begin
         pred_byte[3'(7 - i)] = lfsr_adv[14] ^ lfsr_adv[13];
         lfsr_adv             = {lfsr_adv[13:0], lfsr_adv[14] ^ lfsr_adv[13]};
      end
   end

   // Saturating counter arithmetic, computed one bit wider and clamped.
   always_comb begin
      diff      = data_in ^ pred_byte;
      err_pop   = 4'($countones(diff));
      err_sum   = {1'b0, err_q} + SUM_W'(err_pop);
      byte_sum  = {1'b0, byte_q} + SUM_W'(1);
      err_sat   = err_sum[CNT_W] ? {CNT_W{1'b1}} : err_sum[CNT_W-1:0];
      byte_sat  = byte_sum[CNT_W] ? {CNT_W{1'b1}} : byte_sum[CNT_W-1:0];
      match_inc = match_q + MATCH_W'(1);
      miss_inc  = miss_q + MISS_W'(1);
   end

   // Next-state and output logic.
   always_comb begin
      state_d   = state_q;
      lfsr_d    = lfsr_q;
      b0_d      = b0_q;
      have_b0_d = have_b0_q;
      match_d   = match_q;
      miss_d    = miss_q;
      locked_d  = locked_q;
      bit_err_d = 1'b0;
      err_d     = err_q;
      byte_d    = byte_q;

      if (!enable) begin
         state_d  = ST_IDLE;
         locked_d = 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               state_d   = ST_SEED;
               have_b0_d = 1'b0;
            end
            ST_SEED: begin
               if (data_valid) begin
                  if (!have_b0_q) begin
                     b0_d      = data_in[6:0];
                     have_b0_d = 1'b1;
                  end else begin
                     lfsr_d  = {b0_q, data_in};
                     match_d = '0;
                     state_d = ST_VERIFY;
                  end
               end
            end
            ST_VERIFY: begin
               if (data_valid) begin
                  if (diff == 8'h00) begin
                     lfsr_d  = lfsr_adv;
                     match_d = match_inc;
                     if (match_inc == MATCH_W'(LOCK_BYTES)) begin
                        state_d  = ST_LOCKED;
                        locked_d = 1'b1;
                        miss_d   = '0;
                     end
                  end else begin
                     state_d   = ST_SEED;
                     have_b0_d = 1'b0;
                  end
               end
            end
            ST_LOCKED: begin
               if (data_valid) begin
                  // Free-running on its own prediction so a bad byte cannot corrupt the state.
                  lfsr_d = lfsr_adv;
                  byte_d = byte_sat;
                  if (diff != 8'h00) begin
                     err_d     = err_sat;
                     bit_err_d = 1'b1;
                     miss_d    = miss_inc;
                     if (miss_inc == MISS_W'(LOSS_ERRS)) begin
                        state_d   = ST_SEED;
                        locked_d  = 1'b0;
                        have_b0_d = 1'b0;
                     end
                  end else begin
                     miss_d = '0;
                  end
               end
            end
            default: begin
               state_d  = ST_IDLE;
               locked_d = 1'b0;
            end
         endcase
      end

      if (clear) begin
         err_d  = '0;
         byte_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         lfsr_q    <= '0;
         b0_q      <= '0;
         have_b0_q <= 1'b0;
         match_q   <= '0;
         miss_q    <= '0;
         locked_q  <= 1'b0;
         bit_err_q <= 1'b0;
         err_q     <= '0;
         byte_q    <= '0;
      end else begin
         state_q   <= state_d;
         lfsr_q    <= lfsr_d;
         b0_q      <= b0_d;
         have_b0_q <= have_b0_d;
         match_q   <= match_d;
         miss_q    <= miss_d;
         locked_q  <= locked_d;
         bit_err_q <= bit_err_d;
         err_q     <= err_d;
         byte_q    <= byte_d;
      end
   end

   assign locked     = locked_q;
   assign bit_err    = bit_err_q;
   assign err_count  = err_q;
   assign byte_count = byte_q;

endmodule

// File: tb/tb_prbs15_checker.sv
// Bench for prbs15_checker: directed scenarios plus a randomized stretch, all checked
// every cycle against a bit-sequence model; a CNT_W=4 copy covers saturation.
module tb_prbs15_checker;

   logic        clk;
   logic        rst;
   logic        enable;
   logic [7:0]  data_in;
   logic        data_valid;
   logic        clear;
   logic        locked, bit_err;
   logic [15:0] err_count, byte_count;
   logic        s_locked, s_bit_err;
   logic [3:0]  s_err, s_byte;

   int errors = 0;
   int checks = 0;

   prbs15_checker #(.LOCK_BYTES(4), .LOSS_ERRS(4), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .enable(enable), .data_in(data_in),
      .data_valid(data_valid), .clear(clear), .locked(locked),
      .bit_err(bit_err), .err_count(err_count), .byte_count(byte_count)
   );

   prbs15_checker #(.LOCK_BYTES(4), .LOSS_ERRS(4), .CNT_W(4)) dut_s (
      .clk(clk), .rst(rst), .enable(enable), .data_in(data_in),
      .data_valid(data_valid), .clear(clear), .locked(s_locked),
      .bit_err(s_bit_err), .err_count(s_err), .byte_count(s_byte)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Transmit side: the whole PRBS sequence as a growing list of bits.
   int gbits[$];
   // Checker model: mode 0 idle, 1 seed, 2 verify, 3 locked; hist = last 15 bits, oldest first.
   int hist[$];
   int nxt[$];
   int m_mode, m_have, m_match, m_miss, m_err, m_bytes, m_locked, m_biterr;
   logic [7:0] m_b0;
   logic [7:0] m_pred;

   task automatic gen(output logic [7:0] b);
      b = 8'h00;
      for (int i = 0; i < 8; i++) begin
         int n;
         n = gbits.size();
         gbits.push_back(gbits[n-15] ^ gbits[n-14]);
         b = {b[6:0], gbits[n] != 0};
      end
   endtask

   task automatic predict();
      nxt = hist;
      m_pred = 8'h00;
      for (int i = 0; i < 8; i++) begin
         int nb;
         nb = nxt[0] ^ nxt[1];
         nxt.push_back(nb);
         void'(nxt.pop_front());
         m_pred = {m_pred[6:0], nb != 0};
      end
   endtask

   function automatic int sat(input int x, input int mx);
      return (x > mx) ? mx : x;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_step(input bit en, input bit v, input logic [7:0] d,
                             input bit clr, input bit r);
      if (r) begin
         m_mode = 0; m_have = 0; m_match = 0; m_miss = 0;
         m_err = 0; m_bytes = 0; m_locked = 0; m_biterr = 0;
         return;
      end
      m_biterr = 0;
      if (!en) begin
         m_mode = 0;
         m_locked = 0;
      end else if (m_mode == 0) begin
         m_mode = 1;
         m_have = 0;
      end else if (m_mode == 1 && v) begin
         if (m_have == 0) begin
            m_b0 = d;
            m_have = 1;
         end else begin
            hist.delete();
            for (int i = 6; i >= 0; i--) hist.push_back(int'(m_b0[i]));
            for (int i = 7; i >= 0; i--) hist.push_back(int'(d[i]));
            m_match = 0;
            m_mode = 2;
         end
      end else if (m_mode == 2 && v) begin
         predict();
         if (d == m_pred) begin
            hist = nxt;
            m_match++;
            if (m_match == 4) begin
               m_mode = 3; m_locked = 1; m_miss = 0;
            end
         end else begin
            m_mode = 1;
            m_have = 0;
         end
      end else if (m_mode == 3 && v) begin
         predict();
         hist = nxt;
         m_bytes++;
         if (d != m_pred) begin
            m_err += $countones(d ^ m_pred);
            m_biterr = 1;
            m_miss++;
            if (m_miss == 4) begin
               m_mode = 1; m_locked = 0; m_have = 0;
            end
         end else begin
            m_miss = 0;
         end
      end
      if (clr) begin
         m_err = 0;
         m_bytes = 0;
      end
   endtask

   task automatic cycle(input bit en, input bit v, input logic [7:0] d,
                        input bit clr, input bit r);
      rst = r; enable = en; data_valid = v; data_in = d; clear = clr;
      model_step(en, v, d, clr, r);
      @(posedge clk);
      #1;
      chk("locked", 32'(locked), 32'(m_locked));
      chk("bit_err", 32'(bit_err), 32'(m_biterr));
      chk("err_count", 32'(err_count), 32'(sat(m_err, 65535)));
      chk("byte_count", 32'(byte_count), 32'(sat(m_bytes, 65535)));
      chk("s_locked", 32'(s_locked), 32'(m_locked));
      chk("s_err_count", 32'(s_err), 32'(sat(m_err, 15)));
      chk("s_byte_count", 32'(s_byte), 32'(sat(m_bytes, 15)));
   endtask

   task automatic clean();
      logic [7:0] b;
      gen(b);
      cycle(1'b1, 1'b1, b, 1'b0, 1'b0);
   endtask

   task automatic bad(input logic [7:0] mask, input bit clr);
      logic [7:0] b;
      gen(b);
      cycle(1'b1, 1'b1, b ^ mask, clr, 1'b0);
   endtask

   task automatic arm();
      cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   initial begin
      int vcnt;
      logic [7:0] b;
      for (int i = 0; i < 15; i++) gbits.push_back(1);
      rst = 1'b1; enable = 1'b0; data_valid = 1'b0; data_in = 8'h00; clear = 1'b0;

      // Reset state
      cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      chk("reset_locked", 32'(locked), 32'd0);
      chk("reset_err", 32'(err_count), 32'd0);
      chk("reset_bytes", 32'(byte_count), 32'd0);

      // Clean lock: locked rises on byte 6, then 10 checked bytes
      cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      for (int i = 1; i <= 6; i++) begin
         clean();
         if (i == 5) chk("lock_not_yet", 32'(locked), 32'd0);
      end
      chk("lock_at_6", 32'(locked), 32'd1);
      for (int i = 0; i < 10; i++) clean();
      chk("clean_bytes", 32'(byte_count), 32'd10);
      chk("clean_errs", 32'(err_count), 32'd0);

      // Single-bit error
      bad(8'h01, 1'b0);
      chk("single_bit_err", 32'(bit_err), 32'd1);
      chk("single_err_cnt", 32'(err_count), 32'd1);
      chk("single_locked", 32'(locked), 32'd1);
      clean();
      chk("single_pulse_end", 32'(bit_err), 32'd0);
      for (int i = 0; i < 5; i++) clean();
      chk("single_no_more", 32'(err_count), 32'd1);

      // Full-byte error
      bad(8'hFF, 1'b0);
      chk("full_err_cnt", 32'(err_count), 32'd9);

      // Disarm while locked retains counters; then a corrupt VERIFY byte reseeds
      cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      chk("disarm_locked", 32'(locked), 32'd0);
      chk("disarm_err", 32'(err_count), 32'd9);
      chk("disarm_bytes", 32'(byte_count), 32'd18);
      cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      clean(); clean(); clean();
      bad(8'h80, 1'b0);
      chk("verify_bad_no_err", 32'(err_count), 32'd9);
      for (int i = 1; i <= 6; i++) begin
         clean();
         if (i == 5) chk("verify_relock_not_yet", 32'(locked), 32'd0);
      end
      chk("verify_relock", 32'(locked), 32'd1);

      // Loss of lock and relock
      for (int i = 0; i < 3; i++) bad(8'($urandom_range(1, 255)), 1'b0);
      clean();
      chk("loss_held", 32'(locked), 32'd1);
      for (int i = 1; i <= 4; i++) begin
         bad(8'($urandom_range(1, 255)), 1'b0);
         if (i == 3) chk("loss_before_4th", 32'(locked), 32'd1);
      end
      chk("loss_on_4th", 32'(locked), 32'd0);
      for (int i = 0; i < 6; i++) clean();
      chk("loss_relock", 32'(locked), 32'd1);

      // Valid gaps: a byte every 3rd cycle
      cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      vcnt = 0;
      for (int i = 0; i < 42; i++) begin
         if (i % 3 == 2) begin
            clean();
            vcnt++;
            if (vcnt == 6) chk("gap_lock", 32'(locked), 32'd1);
         end else begin
            cycle(1'b1, 1'b0, 8'($urandom), 1'b0, 1'b0);
         end
      end
      chk("gap_bytes", 32'(byte_count), 32'd8);
      chk("gap_errs", 32'(err_count), 32'd0);

      // Clear coinciding with an errored byte
      bad(8'h10, 1'b1);
      chk("clear_err", 32'(err_count), 32'd0);
      chk("clear_bytes", 32'(byte_count), 32'd0);

      // Saturation: 20 full-byte errors interleaved with clean bytes
      for (int i = 0; i < 20; i++) begin
         bad(8'hFF, 1'b0);
         clean();
      end
      chk("sat_s_err", 32'(s_err), 32'd15);
      chk("sat_s_bytes", 32'(s_byte), 32'd15);
      chk("sat_err", 32'(err_count), 32'd160);
      chk("sat_bytes", 32'(byte_count), 32'd40);

      // Randomized traffic: gaps, errors, occasional clear and disarm
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 99) < 3) begin
            cycle(1'b0, 1'($urandom), 8'($urandom), 1'b0, 1'b0);
         end else if ($urandom_range(0, 3) != 0) begin
            gen(b);
            if ($urandom_range(0, 9) == 0) b = b ^ 8'($urandom_range(1, 255));
            cycle(1'b1, 1'b1, b, $urandom_range(0, 49) == 0, 1'b0);
         end else begin
            cycle(1'b1, 1'b0, 8'($urandom), $urandom_range(0, 49) == 0, 1'b0);
         end
      end

      // Reset while locked overrides clear and enable
      arm();
      for (int i = 0; i < 8; i++) clean();
      chk("pre_rst_locked", 32'(locked), 32'd1);
      bad(8'h03, 1'b0);
      cycle(1'b1, 1'b1, 8'h00, 1'b1, 1'b1);
      chk("rst_locked", 32'(locked), 32'd0);
      chk("rst_bit_err", 32'(bit_err), 32'd0);
      chk("rst_err", 32'(err_count), 32'd0);
      chk("rst_bytes", 32'(byte_count), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/prbs15_checker.md
# prbs15_checker

Downstream consumer of the PRBS-15 byte stream. It takes the 8-bit stream produced by the PRBS generator and self-synchronises a local PRBS-15 LFSR to it. Once locked, it predicts every following byte and counts bit errors and checked bytes. Checking is armed by a level input, normally driven from the pattern detector's `pattern_detected`, so measurement starts only after the preamble pattern has been seen.

## Interface
Parameters:
- `LOCK_BYTES`, 4, consecutive matching bytes in VERIFY needed to declare lock (≥1).
- `LOSS_ERRS`, 4, consecutive mismatching bytes in LOCKED that drop lock (≥1).
- `CNT_W`, 16, width of the error and byte counters.

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  arms checking; level-sensitive.
- `data_in`  in  8  PRBS byte; bit 7 is the earliest bit in sequence order.
- `data_valid`  in  1  qualifies `data_in`; a byte is consumed on any edge where it is high.
- `clear`  in  1  synchronously zeroes both counters.
- `locked`  out  1  checker is in LOCKED.
- `bit_err`  out  1  one-cycle pulse: the byte consumed in LOCKED mismatched.
- `err_count`  out  CNT_W  accumulated bit errors; saturating.
- `byte_count`  out  CNT_W  bytes checked while LOCKED; saturating.

## Operation
- **LFSR.** 15-bit state `s[14:0]`, polynomial x^15+x^14+1.
  - New bit = `s[14]^s[13]`; `s <= {s[13:0], new}`.
  - Predicted byte = 8 successive new bits, first-generated bit in bit 7.
  - The LFSR advances only on consumed bytes.
- **States:** IDLE, SEED, VERIFY, LOCKED.
- **IDLE.** Entered on reset or whenever `enable`=0; `enable`=0 wins over every other transition. `enable`=1 → SEED.
- **SEED.** Collects two consumed bytes b0, b1.
  - After b1: `s <= {b0[6:0], b1}`, then → VERIFY with the match counter at 0.
  - A byte consumed in SEED is never compared.
- **VERIFY.** Each consumed byte is compared with the prediction.
  - Match: match counter +1. Reaching `LOCK_BYTES` → LOCKED.
  - Mismatch: → SEED. The mismatching byte is not reused.
  - Counters do not change in VERIFY.
- **LOCKED.** The LFSR advances from its own prediction, never from received data, so an error does not propagate.
  - Every consumed byte: `byte_count` +1.
  - Mismatch: `err_count += popcount(data_in ^ predicted)` (range 1..8), `bit_err`=1 for one cycle, consecutive-mismatch counter +1.
  - Match: consecutive-mismatch counter cleared.
  - Consecutive-mismatch counter reaching `LOSS_ERRS` → SEED and `locked` drops. That byte is still counted.
- **Arithmetic.** Counters saturate at 2^CNT_W−1 with no wrap. The addition is computed at CNT_W+1 bits and then clamped.
- **Clear.** `clear` zeroes both counters on the next edge.
  - `clear` with a simultaneous increment: `clear` wins, and that byte is not counted.
  - `clear` has no effect on the FSM.
- **Counter retention.** Counters hold their values across IDLE, SEED and VERIFY. Only `rst` or `clear` zeroes them.
- **All-zero seed.** If the seed is all-zero (stuck-at-0 input), VERIFY of zero bytes matches. This is accepted: a stuck-zero link reports lock.
  - The bench must not treat this as a checker bug.
  - Upstream never emits 15 consecutive zeros in valid PRBS-15.

## Timing
- All outputs are registered.
- **Reset values:** `locked`=0, `bit_err`=0, `err_count`=0, `byte_count`=0, state IDLE.
- **Arming:** `enable` rising at edge k → SEED from edge k. The first byte consumed at edge k+1 or later is b0.
- **Lock latency:** `locked` rises on the edge that consumes the (2+`LOCK_BYTES`)-th valid byte after SEED entry, i.e. byte 6 with defaults.
- **Error latency:** `bit_err` and the counter updates become visible on the edge that consumes the byte (one cycle after the byte is presented).
- **Loss of lock:** `locked` falls on the edge that consumes the `LOSS_ERRS`-th consecutive bad byte.
- **Valid gaps:** `data_valid`=0 cycles are arbitrary. State, LFSR and counters hold through them, and `bit_err` is 0.
- **Disarm:** `enable` low at any edge → IDLE and `locked`=0 on that edge. A byte consumed in the same cycle is ignored.
- **Reset mid-operation:** `rst` at any edge → all reset values on that edge. `rst` overrides `clear` and `enable`.

## Test plan
- **Clean lock.** Reset, then `enable`=1, then continuous clean PRBS-15 bytes from seed 0x7FFF with `data_valid`=1.
  - `locked` rises after byte 6.
  - After 10 further bytes: `byte_count`=10, `err_count`=0, `bit_err` never high.
- **Single-bit error.** While locked, XOR one byte with 0x01.
  - `bit_err` pulses for exactly 1 cycle, `err_count`=1, `locked` stays 1.
  - Subsequent clean bytes produce no further errors.
- **Full-byte error.** While locked, XOR one byte with 0xFF → `err_count` increases by 8.
  - Also: a VERIFY-phase corrupt byte re-enters SEED, and lock takes 6 more clean bytes.
- **Loss of lock and relock.** With `LOSS_ERRS`=4, corrupt 3 consecutive bytes, then send a clean byte.
  - Lock is held.
  - Then corrupt 4 consecutive bytes → `locked` falls on the 4th.
  - Clean data then relocks after 6 bytes.
- **Valid gaps.** `data_valid` high every 3rd cycle on a clean stream.
  - Lock after 6 valid bytes.
  - `err_count`=0, and `byte_count` counts only valid locked bytes.
- **Clear, saturation and reset.** Cover each of the following:
  - `clear` asserted in the same cycle as an errored byte → both counters read 0.
  - With `CNT_W`=4, 20 errored bytes → `err_count` holds at 15.
  - `rst` while locked → all outputs 0 on the next edge.
  - `enable` dropped while locked → `locked`=0 and the counters retain their values.
